// File: rtl/conf_dispatcher.sv
// Configuration dispatcher: presents (target, data) words on the shared conf_bus/sel port,
// holds sel until the addressed target acknowledges, and records the first error since reset.
module conf_dispatcher #(
  parameter int DATA_WIDTH   = 8,
  parameter int SELECT_WIDTH = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic                      conf_clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [SELECT_WIDTH-1:0]   in_sel,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     conf_bus,
  output logic [SELECT_WIDTH-1:0]   sel,
  input  logic [2**SELECT_WIDTH-1:0] conf_ack,
  output logic                      busy,
  output logic                      cfg_done,
  output logic [7:0]                cfg_count,
  output logic [1:0]                err_code,
  output logic [SELECT_WIDTH-1:0]   err_sel
);

  localparam int NT = 2**SELECT_WIDTH;
  localparam logic [7:0] LAST_TICK = 8'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ACKED   = 2'b10;
  localparam logic [1:0] ERR_NULL    = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;

  state_t                    state_reg, state_next;
  logic [DATA_WIDTH-1:0]     bus_reg, bus_next;
  logic [SELECT_WIDTH-1:0]   sel_reg, sel_next;
  logic [7:0]                tick_reg, tick_next;
  logic                      done_reg, done_next;
  logic [7:0]                count_reg, count_next;
  logic [1:0]                err_code_reg, err_code_next;
  logic [SELECT_WIDTH-1:0]   err_sel_reg, err_sel_next;

  // Per-target ack decode; target 0 is "no target" and never acknowledges.
  logic [NT-1:0] in_hit, cur_hit;
  for (genvar gi = 0; gi < NT; gi++) begin : g_ack
    assign in_hit[gi]  = (gi != 0) && conf_ack[gi] && (in_sel  == SELECT_WIDTH'(gi));
    assign cur_hit[gi] = (gi != 0) && conf_ack[gi] && (sel_reg == SELECT_WIDTH'(gi));
  end

  logic in_acked, cur_acked;
  assign in_acked  = |in_hit;
  assign cur_acked = |cur_hit;

  always_ff @(posedge conf_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      bus_reg      <= '0;
      sel_reg      <= '0;
      tick_reg     <= '0;
      done_reg     <= 1'b0;
      count_reg    <= '0;
      err_code_reg <= ERR_NONE;
      err_sel_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      bus_reg      <= bus_next;
      sel_reg      <= sel_next;
      tick_reg     <= tick_next;
      done_reg     <= done_next;
      count_reg    <= count_next;
      err_code_reg <= err_code_next;
      err_sel_reg  <= err_sel_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus_next      = bus_reg;
    sel_next      = sel_reg;
    tick_next     = tick_reg;
    done_next     = 1'b0;
    count_next    = count_reg;
    err_code_next = err_code_reg;
    err_sel_next  = err_sel_reg;

    case (state_reg)
      IDLE: begin
        sel_next = '0;
        if (in_valid) begin
          if (in_sel == '0) begin
            if (err_code_reg == ERR_NONE) begin
              err_code_next = ERR_NULL;
              err_sel_next  = in_sel;
            end
          end else if (in_acked) begin
            // Target already latched a word; it would silently drop this one.
            if (err_code_reg == ERR_NONE) begin
              err_code_next = ERR_ACKED;
              err_sel_next  = in_sel;
            end
          end else begin
            bus_next   = in_data;
            sel_next   = in_sel;
            tick_next  = '0;
            state_next = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        tick_next = tick_reg + 8'd1;
        if (cur_acked) begin
          sel_next   = '0;
          done_next  = 1'b1;
          count_next = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
          state_next = RELEASE;
        end else if (tick_reg == LAST_TICK) begin
          sel_next   = '0;
          state_next = RELEASE;
          if (err_code_reg == ERR_NONE) begin
            err_code_next = ERR_TIMEOUT;
            err_sel_next  = sel_reg;
          end
        end
      end
      RELEASE: begin
        sel_next   = '0;
        state_next = IDLE;
      end
      default: begin
        sel_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_reg == IDLE) && !reset;
  assign busy      = (state_reg != IDLE);
  assign conf_bus  = bus_reg;
  assign sel       = sel_reg;
  assign cfg_done  = done_reg;
  assign cfg_count = count_reg;
  assign err_code  = err_code_reg;
  assign err_sel   = err_sel_reg;

endmodule

// File: tb/tb_conf_dispatcher.sv
// Bench for conf_dispatcher: transaction-level reference model compared every cycle,
// plus literal expectations after each directed scenario.
module tb_conf_dispatcher;

  localparam int DW = 8;
  localparam int SW = 3;
  localparam int NT = 8;
  localparam int TO = 16;

  logic          conf_clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_sel = '0;
  logic          in_ready;
  logic [DW-1:0] conf_bus;
  logic [SW-1:0] sel;
  logic [NT-1:0] conf_ack;
  logic          busy;
  logic          cfg_done;
  logic [7:0]    cfg_count;
  logic [1:0]    err_code;
  logic [SW-1:0] err_sel;

  conf_dispatcher #(.DATA_WIDTH(DW), .SELECT_WIDTH(SW), .TIMEOUT(TO)) dut (
    .conf_clk(conf_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sel(in_sel), .in_ready(in_ready), .conf_bus(conf_bus), .sel(sel),
    .conf_ack(conf_ack), .busy(busy), .cfg_done(cfg_done), .cfg_count(cfg_count),
    .err_code(err_code), .err_sel(err_sel)
  );

  initial forever #5 conf_clk = ~conf_clk;

  // Target models: an auto-acking target latches its ack at the first edge it sees its sel.
  logic [NT-1:0] ack_q, ack_auto = '0, ack_clr = '0, ack_force = '0;
  assign conf_ack = ack_q | ack_force;

  always @(posedge conf_clk or posedge reset) begin
    if (reset) ack_q <= '0;
    else
      for (int i = 1; i < NT; i++)
        if (ack_clr[i]) ack_q[i] <= 1'b0;
        else if (ack_auto[i] && sel == SW'(i)) ack_q[i] <= 1'b1;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int sel_cycles = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one word in flight at most, tracked by its target and age.
  int   m_target = 0, m_age = 0, m_count = 0, m_err = 0, m_err_sel = 0;
  bit   m_release = 0, m_done = 0;
  logic [7:0] m_bus = '0;

  task automatic record(input int code, input int s);
    if (m_err == 0) begin
      m_err = code;
      m_err_sel = s;
    end
  endtask

  initial forever begin
    @(posedge conf_clk or posedge reset);
    if (reset) begin
      m_target = 0; m_age = 0; m_count = 0; m_err = 0; m_err_sel = 0;
      m_release = 0; m_done = 0; m_bus = '0;
    end else if (m_release) begin
      m_release = 0;
      m_done = 0;
    end else if (m_target != 0) begin
      m_age++;
      if (conf_ack[m_target]) begin
        m_done = 1;
        m_count = (m_count < 255) ? m_count + 1 : 255;
        m_release = 1;
        m_target = 0;
      end else if (m_age == TO) begin
        record(1, m_target);
        m_release = 1;
        m_target = 0;
      end
    end else if (in_valid) begin
      if (in_sel == 0) record(3, 0);
      else if (conf_ack[in_sel]) record(2, int'(in_sel));
      else begin
        m_target = int'(in_sel);
        m_bus = in_data;
        m_age = 0;
      end
    end
  end

  initial forever begin
    @(negedge conf_clk);
    #1;
    chk("sel", int'(sel), m_target);
    chk("conf_bus", int'(conf_bus), int'(m_bus));
    chk("busy", int'(busy), int'(m_target != 0 || m_release));
    chk("in_ready", int'(in_ready), int'(m_target == 0 && !m_release && !reset));
    chk("cfg_done", int'(cfg_done), int'(m_done));
    chk("cfg_count", int'(cfg_count), m_count);
    chk("err_code", int'(err_code), m_err);
    chk("err_sel", int'(err_sel), m_err_sel);
    if (sel != 0) sel_cycles++;
    if (cfg_done) done_cnt++;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge conf_clk);
    while (!in_ready && n < 100) begin
      @(negedge conf_clk);
      n++;
    end
    if (!in_ready) chk("wait_idle_timeout", int'(in_ready), 1);
  endtask

  task automatic send(input int s, input logic [7:0] d);
    @(negedge conf_clk);
    in_valid = 1'b1;
    in_sel = SW'(s);
    in_data = d;
    @(negedge conf_clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge conf_clk);
    reset = 1'b1;
    @(negedge conf_clk);
    reset = 1'b0;
  endtask

  task automatic clear_counters();
    sel_cycles = 0;
    done_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ack_auto = 8'b0000_0110;
    repeat (2) @(negedge conf_clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_count", int'(cfg_count), 0);
    chk("rst_err", int'(err_code), 0);
    @(negedge conf_clk);
    reset = 1'b0;

    // Good write to target 1, which acks at the first edge it sees sel.
    wait_idle();
    clear_counters();
    send(1, 8'h03);
    wait_idle();
    #2;
    chk("w1_sel_cycles", sel_cycles, 2);
    chk("w1_done", done_cnt, 1);
    chk("w1_count", int'(cfg_count), 1);
    chk("w1_err", int'(err_code), 0);
    chk("w1_bus", int'(conf_bus), 3);

    // Rewrite of target 1 is rejected; a word to target 2 follows on the very next edge.
    clear_counters();
    @(negedge conf_clk);
    in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h05;
    @(negedge conf_clk);
    #2;
    chk("rej_ready", int'(in_ready), 1);
    chk("rej_err", int'(err_code), 2);
    chk("rej_err_sel", int'(err_sel), 1);
    in_sel = 3'd2; in_data = 8'h22;
    @(negedge conf_clk);
    in_valid = 1'b0;
    wait_idle();
    #2;
    chk("b2b_count", int'(cfg_count), 2);
    chk("b2b_bus", int'(conf_bus), 8'h22);
    chk("b2b_sel_cycles", sel_cycles, 2);
    chk("b2b_err", int'(err_code), 2);

    // Timeout on target 4, then a good write to target 2 leaves the error intact.
    do_reset();
    clear_counters();
    wait_idle();
    send(4, 8'h44);
    wait_idle();
    #2;
    chk("to_sel_cycles", sel_cycles, 16);
    chk("to_done", done_cnt, 0);
    chk("to_err", int'(err_code), 1);
    chk("to_err_sel", int'(err_sel), 4);
    clear_counters();
    send(2, 8'h5A);
    wait_idle();
    #2;
    chk("after_to_count", int'(cfg_count), 1);
    chk("after_to_done", done_cnt, 1);
    chk("after_to_err", int'(err_code), 1);

    // Ack arriving exactly on the last allowed cycle wins over the timeout.
    do_reset();
    ack_auto = '0;
    wait_idle();
    clear_counters();
    send(6, 8'h66);
    repeat (15) @(negedge conf_clk);
    ack_force = 8'h40;
    wait_idle();
    ack_force = '0;
    #2;
    chk("late_ack_done", done_cnt, 1);
    chk("late_ack_sel_cycles", sel_cycles, 16);
    chk("late_ack_err", int'(err_code), 0);
    chk("late_ack_count", int'(cfg_count), 1);

    // Null target.
    clear_counters();
    send(0, 8'h99);
    wait_idle();
    #2;
    chk("null_err", int'(err_code), 3);
    chk("null_err_sel", int'(err_sel), 0);
    chk("null_sel_cycles", sel_cycles, 0);

    // 260 successful writes across targets 1..7, re-arming each target's ack afterwards.
    do_reset();
    ack_auto = 8'hFE;
    clear_counters();
    for (int n = 0; n < 260; n++) begin
      int t;
      t = 1 + (n % 7);
      wait_idle();
      send(t, 8'(n));
      wait_idle();
      ack_clr = 8'(1 << t);
      @(negedge conf_clk);
      ack_clr = '0;
    end
    #2;
    chk("sat_count", int'(cfg_count), 255);
    chk("sat_done", done_cnt, 260);
    chk("sat_err", int'(err_code), 0);

    // Activity on non-addressed ack bits while waiting on target 5.
    ack_auto = 8'hDE;
    wait_idle();
    clear_counters();
    send(5, 8'hA5);
    for (int k = 0; k < 6; k++) begin
      ack_force = 8'($urandom) & 8'hDF;
      @(negedge conf_clk);
      chk("tog_no_done", int'(cfg_done), 0);
    end
    ack_force = 8'h20;
    wait_idle();
    ack_force = '0;
    #2;
    chk("tog_done", done_cnt, 1);
    chk("tog_err", int'(err_code), 0);
    chk("tog_bus", int'(conf_bus), 8'hA5);

    // Reset while a word is waiting for its ack.
    ack_auto = '0;
    wait_idle();
    send(7, 8'h77);
    repeat (3) @(negedge conf_clk);
    reset = 1'b1;
    #2;
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_count", int'(cfg_count), 0);
    chk("mid_rst_err", int'(err_code), 0);
    chk("mid_rst_bus", int'(conf_bus), 0);
    @(negedge conf_clk);
    reset = 1'b0;
    repeat (2) @(negedge conf_clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
